// File: rtl/fp_add_normalizer_pkg.sv
// Shared constants, FSM state type and IEEE-754 single-precision packing helper
// for the float adder normalise/pack stage.
package fp_add_normalizer_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [EXP_W+FRAC_W:0] pack(input logic s,
                                                   input logic [EXP_W-1:0] e,
                                                   input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fp_add_normalizer.sv
// Normalise/pack stage behind float_adder: shifts the raw mantissa sum one bit
// per cycle until the hidden bit is set, then presents a packed single-precision word.
module fp_add_normalizer #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_zero,
    output logic                    out_ovf
);
    import fp_add_normalizer_pkg::*;

    localparam int MW = FRAC_W + 2;
    localparam int XW = EXP_W + 1;
    localparam logic [XW-1:0] EXP_ALL1 = {1'b0, {EXP_W{1'b1}}};

    state_t                 state, state_nx;
    logic                   sign_r, sign_nx;
    logic [MW-1:0]          mant_r, mant_nx;
    logic [XW-1:0]          exp_r, exp_nx, exp_inc;
    logic [EXP_W+FRAC_W:0]  result_nx;
    logic                   zero_nx, ovf_nx, valid_nx;

    always_comb begin
        state_nx  = state;
        sign_nx   = sign_r;
        mant_nx   = mant_r;
        exp_nx    = exp_r;
        result_nx = out_result;
        zero_nx   = out_zero;
        ovf_nx    = out_ovf;
        exp_inc   = exp_r + XW'(1);
        valid_nx  = (state == DONE) && !(out_valid && out_ready);

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_nx  = in_sign;
                    mant_nx  = in_mant;
                    exp_nx   = {1'b0, in_exp};
                    state_nx = NORM;
                end
            end
            NORM: begin
                state_nx = DONE;
                zero_nx  = 1'b0;
                ovf_nx   = 1'b0;
                if (mant_r == '0) begin
                    result_nx = '0;
                    zero_nx   = 1'b1;
                end else if (mant_r[MW-1]) begin
                    // Carry out: one right shift, truncating the dropped LSB
                    if (exp_inc >= EXP_ALL1) begin
                        result_nx = pack(sign_r, EXP_MAX, '0);
                        ovf_nx    = 1'b1;
                    end else begin
                        result_nx = pack(sign_r, exp_inc[EXP_W-1:0], mant_r[FRAC_W:1]);
                    end
                end else if (mant_r[FRAC_W]) begin
                    result_nx = pack(sign_r, exp_r[EXP_W-1:0], mant_r[FRAC_W-1:0]);
                end else if (exp_r <= XW'(1)) begin
                    result_nx = pack(sign_r, '0, '0);
                    zero_nx   = 1'b1;
                end else begin
                    mant_nx  = mant_r << 1;
                    exp_nx   = exp_r - XW'(1);
                    state_nx = NORM;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    zero_nx  = 1'b0;
                    ovf_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control and visible outputs: cleared asynchronously so an abort is immediate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            state      <= state_nx;
            in_ready   <= (state_nx == IDLE);
            out_valid  <= valid_nx;
            out_result <= result_nx;
            out_zero   <= zero_nx;
            out_ovf    <= ovf_nx;
        end
    end

    // Working operand; always reloaded on acceptance, so no reset needed
    always_ff @(posedge clk) begin
        sign_r <= sign_nx;
        mant_r <= mant_nx;
        exp_r  <= exp_nx;
    end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Self-checking bench for fp_add_normalizer: directed cases plus randomized
// operands against a leading-one based reference model.
module tb_fp_add_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    fp_add_normalizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: locate the leading one, derive the shift count and the
    // resulting exponent directly instead of stepping cycle by cycle.
    task automatic model(input logic s, input logic [7:0] e, input logic [24:0] m,
                         output logic [31:0] r, output logic z, output logic o,
                         output int lat);
        int p, k, ei;
        logic [24:0] sh;
        r = 32'h0; z = 1'b0; o = 1'b0; lat = 2;
        ei = int'(e);
        p = -1;
        for (int i = 0; i < 25; i++) if (m[i]) p = i;
        if (p < 0) begin
            z = 1'b1;
        end else if (p == 24) begin
            if (ei + 1 >= 255) begin
                r = {s, 8'hFF, 23'h0};
                o = 1'b1;
            end else begin
                sh = m >> 1;
                r = {s, 8'(ei + 1), sh[22:0]};
            end
        end else begin
            k = 23 - p;
            if (k == 0 || ei - k >= 1) begin
                sh = m << k;
                r = {s, 8'(ei - k), sh[22:0]};
                lat = 2 + k;
            end else begin
                r = {s, 31'h0};
                z = 1'b1;
                lat = 2 + ((ei > 1) ? ei - 1 : 0);
            end
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [24:0] m, input int hold, output logic [31:0] got);
        logic [31:0] xr;
        logic        xz, xo;
        int          xl, lat;
        model(s, e, m, xr, xz, xo, xl);
        chk({tag, " in_ready idle"}, {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        @(posedge clk); #1;
        in_valid = 1'b0; in_mant = 25'($urandom); in_exp = 8'($urandom);
        chk({tag, " in_ready busy"}, {31'h0, in_ready}, 32'h0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(xl));
        chk({tag, " result"}, out_result, xr);
        chk({tag, " zero"}, {31'h0, out_zero}, {31'h0, xz});
        chk({tag, " ovf"}, {31'h0, out_ovf}, {31'h0, xo});
        got = out_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold result"}, out_result, xr);
            chk({tag, " hold valid"}, {31'h0, out_valid}, 32'h1);
            chk({tag, " hold in_ready"}, {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " valid drop"}, {31'h0, out_valid}, 32'h0);
        chk({tag, " flags clear"}, {30'h0, out_zero, out_ovf}, 32'h0);
        chk({tag, " back idle"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] got;
        logic [24:0] m;
        int p;
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'h0;
        in_mant = 25'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'h0, in_ready}, 32'h0);
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset out_result", out_result, 32'h0);
        chk("reset flags", {30'h0, out_zero, out_ovf}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("carry 4.0", 1'b0, 8'h80, 25'h1000000, 0, got);
        chk("carry 4.0 const", got, 32'h40800000);
        run_op("carry -4.5", 1'b1, 8'h80, 25'h1200000, 0, got);
        chk("carry -4.5 const", got, 32'hC0900000);
        run_op("shift 0.5", 1'b0, 8'h80, 25'h0200000, 0, got);
        chk("shift 0.5 const", got, 32'h3F000000);
        run_op("zero neg", 1'b1, 8'h45, 25'h0, 0, got);
        chk("zero neg const", got, 32'h00000000);
        run_op("overflow", 1'b0, 8'hFE, 25'h1000000, 0, got);
        chk("overflow const", got, 32'h7F800000);
        run_op("flush", 1'b1, 8'h02, 25'h0000001, 0, got);
        chk("flush const", got, 32'h80000000);
        run_op("backpressure", 1'b0, 8'h7F, 25'h0C00000, 5, got);
        run_op("after bp", 1'b1, 8'h81, 25'h0A00000, 0, got);

        // Abort during normalisation
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h0200000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", {31'h0, out_valid}, 32'h0);
        chk("abort out_result", out_result, 32'h0);
        chk("abort in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post reset", 1'b0, 8'h80, 25'h0200000, 0, got);
        chk("post reset const", got, 32'h3F000000);

        for (int n = 0; n < 200; n++) begin
            p = int'($urandom_range(0, 25));
            if (p == 25) m = 25'h0;
            else m = (25'h1 << p) | (25'($urandom) & ((25'h1 << p) - 25'h1));
            run_op("random", 1'($urandom), 8'($urandom_range(0, 254)), m,
                   int'($urandom_range(0, 2)), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
